// File: rtl/fp_division.sv
// rtl/fp_division.sv - IEEE-754 single-precision restoring divider, fixed 28-cycle latency
// Optional FP_DIV_SPECIAL_CASES_EN: zero/inf/NaN operands and exponent saturation
module fp_division (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] f_1,
  input  logic [31:0] f_2,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        f_nan,
  output logic        f_inf
);
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sign;
  logic signed [9:0]  r_exp_diff;
  logic [23:0]        r_mb;
  logic [24:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic [31:0]        r_s;
  logic               r_nan;
  logic               r_inf;

  logic               w_ge;
  logic [24:0]        w_rem_sub;
  logic               w_hi;
  logic [22:0]        w_frac_pre;
  logic               w_guard;
  logic [23:0]        w_round;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_exp;
  logic [31:0]        w_s;
  logic               w_nan;
  logic               w_inf;

`ifdef FP_DIV_SPECIAL_CASES_EN
  // Operand classes captured at start; exponent 0 means zero (subnormals flushed)
  logic r_a_zero, r_a_inf, r_a_nan, r_b_zero, r_b_inf, r_b_nan;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DIVIDE;
      DIVIDE:  if (r_cnt == 5'd25) w_next = NORM;
      NORM:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == DIVIDE) || (r_state == NORM);
    done = (r_state == DONE);
  end

  assign w_ge      = r_rem >= {1'b0, r_mb};
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  assign w_hi       = r_q[25];
  assign w_frac_pre = w_hi ? r_q[24:2] : r_q[23:1];
  assign w_guard    = w_hi ? r_q[1] : r_q[0];
  assign w_round    = {1'b0, w_frac_pre} + {23'd0, w_guard};
  assign w_frac     = w_round[23] ? 23'd0 : w_round[22:0];
  assign w_exp      = r_exp_diff + (w_hi ? 10'sd127 : 10'sd126) + $signed({9'd0, w_round[23]});

  always_comb begin
    w_s   = {r_sign, w_exp[7:0], w_frac};
    w_nan = 1'b0;
    w_inf = 1'b0;
`ifdef FP_DIV_SPECIAL_CASES_EN
    if (r_a_nan || r_b_nan || (r_a_inf && r_b_inf) || (r_a_zero && r_b_zero)) begin
      w_s   = 32'h7FC0_0000;
      w_nan = 1'b1;
    end else if (r_a_inf || r_b_zero || (w_exp >= 10'sd255)) begin
      w_s   = {r_sign, 8'hFF, 23'd0};
      w_inf = 1'b1;
    end else if (r_a_zero || r_b_inf || (w_exp <= 10'sd0)) begin
      w_s   = {r_sign, 31'd0};
    end
`else
    w_nan = (w_exp[7:0] == 8'hFF) && (w_frac != 23'd0);
    w_inf = (w_exp[7:0] == 8'hFF) && (w_frac == 23'd0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_exp_diff <= '0;
      r_mb       <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_s        <= '0;
      r_nan      <= 1'b0;
      r_inf      <= 1'b0;
`ifdef FP_DIV_SPECIAL_CASES_EN
      {r_a_zero, r_a_inf, r_a_nan, r_b_zero, r_b_inf, r_b_nan} <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_sign     <= f_1[31] ^ f_2[31];
          r_exp_diff <= {2'b00, f_1[30:23]} - {2'b00, f_2[30:23]};
          r_mb       <= {1'b1, f_2[22:0]};
          r_rem      <= {2'b01, f_1[22:0]};
          r_q        <= '0;
          r_cnt      <= '0;
`ifdef FP_DIV_SPECIAL_CASES_EN
          r_a_zero <= (f_1[30:23] == 8'h00);
          r_a_inf  <= (f_1[30:23] == 8'hFF) && (f_1[22:0] == 23'd0);
          r_a_nan  <= (f_1[30:23] == 8'hFF) && (f_1[22:0] != 23'd0);
          r_b_zero <= (f_2[30:23] == 8'h00);
          r_b_inf  <= (f_2[30:23] == 8'hFF) && (f_2[22:0] == 23'd0);
          r_b_nan  <= (f_2[30:23] == 8'hFF) && (f_2[22:0] != 23'd0);
`endif
        end
        DIVIDE: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= {w_rem_sub[23:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          r_s   <= w_s;
          r_nan <= w_nan;
          r_inf <= w_inf;
        end
        default: ;
      endcase
    end
  end

  assign s     = r_s;
  assign f_nan = r_nan;
  assign f_inf = r_inf;
endmodule

// File: doc/fp_division.md
FP_DIVISION -- requirements
Module: fp_division

Interface
REQ-001 The block SHALL have no parameters; the format is fixed to IEEE-754 single precision (1 sign, 8 exponent, 23 fraction bits).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 f_1  input  32  dividend operand, sampled on the accepted start cycle.
REQ-006 f_2  input  32  divisor operand, sampled on the accepted start cycle.
REQ-007 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-008 done  output  1  one-cycle pulse; s, f_nan and f_inf are valid from this cycle on.
REQ-009 s  output  32  quotient {sign, exp, fraction}; held until the next accepted start.
REQ-010 f_nan  output  1  result is NaN; held with s.
REQ-011 f_inf  output  1  result is +/-infinity; held with s.

Function
REQ-012 The FSM SHALL have four states: IDLE -> DIVIDE on start; DIVIDE -> NORM after 26 iterations; NORM -> DONE; DONE -> IDLE unconditionally.
REQ-013 On an accepted start the block SHALL latch sign = f_1[31]^f_2[31], exp_diff = f_1[30:23] - f_2[30:23] (10-bit signed), ma = {1,f_1[22:0]}, mb = {1,f_2[22:0]}, remainder = ma, and counter = 0.
REQ-014 Each DIVIDE cycle SHALL perform one restoring step: if remainder >= mb, shift a quotient bit of 1 into q and set remainder = remainder - mb; otherwise shift in 0. Remainder is then shifted left by 1.
REQ-015 After 26 steps, q[25:0] SHALL equal floor(ma * 2^25 / mb).
REQ-016 In NORM, if q[25]=1: frac = q[24:2], guard = q[1], exp = exp_diff + 127. Otherwise: frac = q[23:1], guard = q[0], exp = exp_diff + 126.
REQ-017 Rounding SHALL be round-half-up: frac = frac + guard. A carry out of frac SHALL zero frac and increment exp.
REQ-018 Outputs SHALL be registered in NORM so that done asserts exactly 28 cycles after the start cycle. Start sampled at cycle 0, DIVIDE runs cycles 1-26, NORM is cycle 27, DONE is cycle 28.
REQ-019 Latency SHALL be identical for all operand values, including special cases.
REQ-020 Start asserted while not in IDLE SHALL be ignored and SHALL NOT alter the latched operands.
REQ-021 f_nan and f_inf SHALL never be asserted together.

Reset
REQ-022 While rst is high: state = IDLE; busy, done, f_nan, f_inf = 0; s = 32'h0000_0000; internal registers cleared.
REQ-023 Reset asserted mid-operation SHALL abort the division with no done pulse; the first start after reset release SHALL be accepted normally.
REQ-024 Start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-025 Macro FP_DIV_SPECIAL_CASES_EN SHALL control special-case handling.
REQ-026 With the macro defined, exponent field 0 SHALL be treated as zero (subnormals flush to zero), and the following SHALL apply:
- NaN input, 0/0, or inf/inf -> s = 32'h7FC0_0000, f_nan = 1.
- Nonzero finite/0 or inf/finite -> signed infinity, f_inf = 1.
- 0/nonzero or finite/inf -> signed zero.
- Final exp >= 255 -> signed infinity, f_inf = 1.
- Final exp <= 0 -> signed zero.
REQ-027 Without the macro, all inputs SHALL be processed arithmetically with the hidden bit forced to 1. The exponent SHALL be truncated to 8 bits. f_nan and f_inf SHALL be derived only from the result fields: exp = 255 with frac != 0 sets f_nan; exp = 255 with frac = 0 sets f_inf.

Verification
REQ-028 f_1 = 0x40400000 (3.0), f_2 = 0x3FC00000 (1.5) -> done at cycle 28 with s = 0x40000000, f_nan = 0, f_inf = 0.
REQ-029 f_1 = 0x3F800000 (1.0), f_2 = 0x40400000 (3.0) -> s = 0x3EAAAAAB (rounding up via guard bit).
REQ-030 f_1 = 0xC0C00000 (-6.0), f_2 = 0x40000000 (2.0) -> s = 0xC0400000; a second start pulsed at cycle 5 is ignored.
REQ-031 With the macro defined: 0x3F800000 / 0x00000000 -> s = 0x7F800000, f_inf = 1; 0x00000000 / 0x00000000 -> s = 0x7FC00000, f_nan = 1.
REQ-032 Start 3.0/1.5, then assert rst at cycle 10 -> no done pulse, all outputs 0; a subsequent start of 1.0/3.0 -> s = 0x3EAAAAAB after 28 cycles.
